// File: rtl/loopback_bist.sv
// rtl/loopback_bist.sv - pattern-generating BIST engine for the 8-bit loopback datapath
// Optional error injection: define LOOPBACK_BIST_ERR_INJECT_EN to add the inject input.
module loopback_bist #(
    parameter int LATENCY   = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           pattern_sel,
    input  logic [7:0]           burst_len,
`ifdef LOOPBACK_BIST_ERR_INJECT_EN
    input  logic                 inject,
`endif
    output logic [7:0]           gen_data,
    input  logic [7:0]           chk_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [7:0]           first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [7:0] len_q;
    logic [1:0] sel_q;
    logic [7:0] idx_q;
    logic [7:0] cmp_idx_q;
    logic [7:0] lfsr_q;
    logic [7:0] pat;
    logic [7:0] inj_mask;
    logic       exp_valid [LATENCY];
    logic [7:0] exp_data  [LATENCY];
    logic       start_ok;
    logic       upstream_valid;
    logic       tail_valid;
    logic       miscompare;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign tail_valid = exp_valid[LATENCY-1];
    assign miscompare = tail_valid && (chk_data != exp_data[LATENCY-1]);

`ifdef LOOPBACK_BIST_ERR_INJECT_EN
    assign inj_mask = {7'd0, inject};
`else
    assign inj_mask = 8'd0;
`endif

    always_comb begin
        pat = 8'd0;
        case (sel_q)
            2'b00:   pat = idx_q;
            2'b01:   pat = idx_q[0] ? 8'hAA : 8'h55;
            2'b10:   pat = 8'd1 << idx_q[2:0];
            default: pat = lfsr_q;
        endcase
    end

    // Any stage ahead of the tail still holding a word means DRAIN is not over.
    always_comb begin
        upstream_valid = 1'b0;
        for (int j = 0; j < LATENCY - 1; j++)
            upstream_valid = upstream_valid | exp_valid[j];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (burst_len == 8'd0) ? DONE : RUN;
            RUN:        if (idx_q == len_q - 8'd1) state_nxt = DRAIN;
            DRAIN:      if (!upstream_valid) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
        pass     = (state == DONE) && (err_count == '0);
        gen_data = (state == RUN) ? (pat ^ inj_mask) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q         <= 8'd0;
            sel_q         <= 2'b00;
            idx_q         <= 8'd0;
            cmp_idx_q     <= 8'd0;
            lfsr_q        <= 8'h01;
            err_count     <= '0;
            first_err_idx <= 8'd0;
            for (int j = 0; j < LATENCY; j++) begin
                exp_valid[j] <= 1'b0;
                exp_data[j]  <= 8'd0;
            end
        end else begin
            // Expected copy carries the clean pattern, never the injected bit.
            exp_valid[0] <= (state == RUN);
            exp_data[0]  <= pat;
            for (int j = 1; j < LATENCY; j++) begin
                exp_valid[j] <= exp_valid[j-1];
                exp_data[j]  <= exp_data[j-1];
            end
            if (start_ok) begin
                len_q         <= burst_len;
                sel_q         <= pattern_sel;
                idx_q         <= 8'd0;
                cmp_idx_q     <= 8'd0;
                lfsr_q        <= 8'h01;
                err_count     <= '0;
                first_err_idx <= 8'd0;
            end else begin
                if (state == RUN) begin
                    idx_q  <= idx_q + 8'd1;
                    lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                end
                if (tail_valid) begin
                    cmp_idx_q <= cmp_idx_q + 8'd1;
                    if (miscompare) begin
                        if (err_count == '0)
                            first_err_idx <= cmp_idx_q;
                        if (err_count != {CNT_WIDTH{1'b1}})
                            err_count <= err_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_loopback_bist.sv
// tb/tb_loopback_bist.sv - directed bench for loopback_bist with a registered loopback stage
module tb_loopback_bist;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'b00;
    logic [7:0]  burst_len = 8'd0;
    logic        inject = 1'b0;
    logic [7:0]  gen_data;
    logic [7:0]  chk_data;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [7:0]  first_err_idx;
    logic [7:0]  lb_q;
    logic [7:0]  force_mask = 8'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) lb_q <= gen_data;
    assign chk_data = lb_q | force_mask;

    loopback_bist #(.LATENCY(1), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pattern_sel   (pattern_sel),
        .burst_len     (burst_len),
`ifdef LOOPBACK_BIST_ERR_INJECT_EN
        .inject        (inject),
`endif
        .gen_data      (gen_data),
        .chk_data      (chk_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that sampled start (word 0 now on gen_data).
    task automatic kick(input logic [1:0] sel, input logic [7:0] len);
        pattern_sel = sel;
        burst_len   = len;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if ({gen_data, busy, done, pass} !== {8'h00, 3'b000}) begin
            n_bad++; $display("FAIL reset_outputs: got %h/%b%b%b want 00/000", gen_data, busy, done, pass);
        end
        n_cmp++; if ({err_count, first_err_idx} !== 24'd0) begin
            n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", err_count, first_err_idx);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_incrementing();
        kick(2'b00, 8'd4);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (gen_data !== 8'(i) || busy !== 1'b1) begin
                n_bad++; $display("FAIL inc_word%0d: got %h busy %b want %h busy 1", i, gen_data, busy, 8'(i));
            end
            tick();
        end
        n_cmp++; if ({busy, done, gen_data} !== {2'b10, 8'h00}) begin
            n_bad++; $display("FAIL inc_drain: got busy %b done %b gen %h want 1 0 00", busy, done, gen_data);
        end
        tick();
        n_cmp++; if ({busy, done, pass, err_count} !== {3'b011, 16'd0}) begin
            n_bad++; $display("FAIL inc_done: got busy %b done %b pass %b err %0d want 0 1 1 0", busy, done, pass, err_count);
        end
    endtask

    task automatic test_lfsr();
        logic [7:0] exp [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        kick(2'b11, 8'd5);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (gen_data !== exp[i]) begin
                n_bad++; $display("FAIL lfsr_word%0d: got %h want %h", i, gen_data, exp[i]);
            end
            tick();
        end
        tick();
        n_cmp++; if ({done, pass, err_count} !== {2'b11, 16'd0}) begin
            n_bad++; $display("FAIL lfsr_done: got done %b pass %b err %0d want 1 1 0", done, pass, err_count);
        end
    endtask

    task automatic test_stuck_bit();
        force_mask = 8'h80;
        kick(2'b01, 8'd4);
        repeat (5) tick();
        n_cmp++; if ({done, pass, err_count, first_err_idx} !== {2'b10, 16'd2, 8'd0}) begin
            n_bad++; $display("FAIL stuck7: got done %b pass %b err %0d first %0d want 1 0 2 0", done, pass, err_count, first_err_idx);
        end
        force_mask = 8'h00;
    endtask

    // Restarts from DONE directly; walking one with chk bit0 stuck fails every word except word 0.
    task automatic test_back_to_back();
        force_mask = 8'h01;
        kick(2'b10, 8'd8);
        repeat (9) tick();
        n_cmp++; if ({done, pass, err_count, first_err_idx} !== {2'b10, 16'd7, 8'd1}) begin
            n_bad++; $display("FAIL walk_stuck0: got done %b pass %b err %0d first %0d want 1 0 7 1", done, pass, err_count, first_err_idx);
        end
        force_mask = 8'h00;
        kick(2'b10, 8'd8);
        n_cmp++; if ({err_count, busy, done} !== {16'd0, 2'b10}) begin
            n_bad++; $display("FAIL restart_clear: got err %0d busy %b done %b want 0 1 0", err_count, busy, done);
        end
        repeat (9) tick();
        n_cmp++; if ({done, pass, err_count} !== {2'b11, 16'd0}) begin
            n_bad++; $display("FAIL walk_clean: got done %b pass %b err %0d want 1 1 0", done, pass, err_count);
        end
    endtask

    task automatic test_zero_length();
        kick(2'b00, 8'd0);
        n_cmp++; if ({done, busy, pass, gen_data} !== {3'b101, 8'h00}) begin
            n_bad++; $display("FAIL zero_len: got done %b busy %b pass %b gen %h want 1 0 1 00", done, busy, pass, gen_data);
        end
        tick();
        n_cmp++; if ({done, busy} !== 2'b10) begin
            n_bad++; $display("FAIL zero_len_hold: got done %b busy %b want 1 0", done, busy);
        end
    endtask

    task automatic test_reset_midrun();
        force_mask = 8'h80;
        kick(2'b01, 8'd200);
        repeat (50) tick();
        // Words 0..48 compared so far; the 25 even ones (0x55) fail.
        n_cmp++; if ({gen_data, err_count} !== {8'h55, 16'd25}) begin
            n_bad++; $display("FAIL midrun_pre: got gen %h err %0d want 55 25", gen_data, err_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        force_mask = 8'h00;
        n_cmp++; if ({gen_data, err_count, first_err_idx, busy, done} !== {8'h00, 16'd0, 8'd0, 2'b00}) begin
            n_bad++; $display("FAIL midrun_reset: got gen %h err %0d first %0d busy %b done %b want 00 0 0 0 0", gen_data, err_count, first_err_idx, busy, done);
        end
        tick();
        kick(2'b10, 8'd3);
        n_cmp++; if (gen_data !== 8'h01) begin
            n_bad++; $display("FAIL rerun_word0: got %h want 01", gen_data);
        end
        repeat (4) tick();
        n_cmp++; if ({done, pass, err_count} !== {2'b11, 16'd0}) begin
            n_bad++; $display("FAIL rerun_done: got done %b pass %b err %0d want 1 1 0", done, pass, err_count);
        end
    endtask

`ifdef LOOPBACK_BIST_ERR_INJECT_EN
    task automatic test_inject();
        kick(2'b10, 8'd8);
        repeat (3) tick();
        inject = 1'b1;
        #1;
        n_cmp++; if (gen_data !== 8'h09) begin
            n_bad++; $display("FAIL inject_word: got %h want 09", gen_data);
        end
        tick();
        inject = 1'b0;
        repeat (5) tick();
        n_cmp++; if ({done, pass, err_count, first_err_idx} !== {2'b10, 16'd1, 8'd3}) begin
            n_bad++; $display("FAIL inject_result: got done %b pass %b err %0d first %0d want 1 0 1 3", done, pass, err_count, first_err_idx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_incrementing();
        test_lfsr();
        test_stuck_bit();
        test_back_to_back();
        test_zero_length();
        test_reset_midrun();
`ifdef LOOPBACK_BIST_ERR_INJECT_EN
        test_inject();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/loopback_bist.md
# loopback_bist

Built-in self-test engine for the 8-bit loopback datapath in the JTAG/IEEE 1687 instrument network. The block generates a selectable test pattern and drives it into the loopback stage's `data_in`. It takes the loopback stage's `data_out` back in and compares it against a latency-aligned copy of the generated stream. It reports busy/done/pass, a saturating error count and the index of the first miscompare, so a 1687 TDR or the bench can run a loopback check without external pattern logic.

## Interface
- `LATENCY`, default 1: cycles from `gen_data` to the matching `chk_data` through the loopback stage. Must be ≥ 1.
- `CNT_WIDTH`, default 16: width of `err_count`.
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: start pulse. Sampled only in IDLE or DONE.
- `pattern_sel`, input, 2: 00 incrementing, 01 alternating 0x55/0xAA, 10 walking one, 11 LFSR.
- `burst_len`, input, 8: number of words to send. Captured on `start`.
- `gen_data`, output, 8: stimulus word, connected to the loopback stage's `data_in`.
- `chk_data`, input, 8: return word, connected to the loopback stage's `data_out`.
- `busy`, output, 1: high in RUN and DRAIN.
- `done`, output, 1: high in DONE.
- `pass`, output, 1: `err_count == 0`. Meaningful only while `done` is high.
- `err_count`, output, CNT_WIDTH: number of miscompares. Saturates at all-ones.
- `first_err_idx`, output, 8: word index of the first miscompare.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- Reset values: state IDLE, `gen_data` 0x00, `busy` 0, `done` 0, `pass` 0, `err_count` 0, `first_err_idx` 0; the expected pipeline is cleared.
- IDLE or DONE with `start`=1:
  - Clear `err_count`, `first_err_idx` and the word index.
  - Latch `burst_len` and `pattern_sel`.
  - Go to RUN; if `burst_len`==0, go straight to DONE instead, with `pass`=1.
- RUN:
  - One word per cycle on `gen_data`, words 0 to N-1.
  - After word N-1, go to DRAIN.
  - `start` is ignored.
- DRAIN:
  - `gen_data` = 0x00.
  - Lasts until the last word has been compared, then go to DONE.
- DONE: results are held until the next `start` or `reset`.
- Patterns for word i:
  - 00 (incrementing): i mod 256.
  - 01 (alternating): 0x55 for even i, 0xAA for odd i.
  - 10 (walking one): 1 << (i mod 8).
  - 11 (LFSR): Fibonacci, x^8+x^6+x^5+x^4+1. Seed 0x01 at word 0; each step shifts left and sets new bit0 = b7^b5^b4^b3.
- Expected pipeline:
  - LATENCY stages, each holding {valid, data} and loaded from the generated word.
  - A comparison happens when the tail stage is valid.
- On a miscompare:
  - `err_count` increments, saturating at all-ones.
  - If this is the first error, `first_err_idx` is set to that word's index.
- `gen_data` is 0x00 whenever the state is not RUN.
- `reset` asserted mid-run returns the block to reset values on the next edge; no partial results survive.

## Timing
- `start` sampled at edge k → after edge k the state is RUN and word 0 is on `gen_data`.
- Word i is on `gen_data` after edge k+i.
- Word i is compared against `chk_data` at edge k+i+LATENCY+1.
- For N ≥ 1: `done` rises after edge k+N+LATENCY, and `busy` falls at the same edge.
- For N = 0: `done` rises after edge k.
- `err_count` and `first_err_idx` update at the edge where the comparison happens; they are stable once `done`=1.

## Configuration
- Macro: `LOOPBACK_BIST_ERR_INJECT_EN`.
- Defined:
  - Adds input `inject` (1 bit).
  - When `inject`=1 in RUN, bit0 of that cycle's `gen_data` is inverted. The expected pipeline still receives the uninverted word, so exactly one miscompare is produced per injected cycle.
- Undefined: the `inject` port and its logic are absent, and behaviour is exactly as described above.

## Test plan
- Bench setup for all cases: LATENCY=1 with the registered loopback stage in the loop.
- Incrementing: `pattern_sel`=00, `burst_len`=4, `start` → `gen_data` 00,01,02,03; `done` rises 5 cycles after `start`; `pass`=1, `err_count`=0.
- LFSR: `pattern_sel`=11, `burst_len`=5 → `gen_data` 01,02,04,08,11; `pass`=1.
- Stuck bit: force `chk_data`[7]=1 with `pattern_sel`=01, `burst_len`=4 → `err_count`=2 (the 0x55 words), `first_err_idx`=0, `pass`=0.
- Zero length: `burst_len`=0 → `done`=1 the cycle after `start`, `busy` never rises, `pass`=1.
- Reset mid-run: `burst_len`=200, assert `reset` at word 50 → next cycle IDLE, `gen_data`=0, `err_count`=0, `done`=0. A new `start` then runs cleanly.
- With `LOOPBACK_BIST_ERR_INJECT_EN`: `pattern_sel`=10, `burst_len`=8, `inject` high on word 3 → `gen_data` 0x09 on that cycle, `err_count`=1, `first_err_idx`=3.
